// File: rtl/bram_pkg.sv
// Shared constants and helpers for the dual-port block RAM and its clear sequencer.
package bram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;
  localparam int RDW_NO_CHANGE   = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clear_state_t;

  function automatic int calc_nbytes(input int width, input int byte_width);
    return width / byte_width;
  endfunction

endpackage

// File: rtl/bram_clear_fsm.sv
// Post-reset clear sequencer: walks every address once, writing zero through
// port A's write path, then hands the array to the ports.
module bram_clear_fsm
  import bram_pkg::*;
#(
  parameter int ADDR_BITS      = 10,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 init_busy,
  output logic                 clear_write,
  output logic [ADDR_BITS-1:0] clear_addr
);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

  clear_state_t state;

  // State, clear address and busy flag advance together so busy drops with READY.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= CLEAR_ON_RESET ? CLEAR : READY;
      clear_addr <= '0;
      init_busy  <= CLEAR_ON_RESET;
    end else begin
      case (state)
        CLEAR: begin
          if (clear_addr == LAST_ADDR) begin
            state     <= READY;
            init_busy <= 1'b0;
          end else begin
            clear_addr <= clear_addr + 1'b1;
          end
        end
        READY: begin
          init_busy <= 1'b0;
        end
        default: begin
          state     <= READY;
          init_busy <= 1'b0;
        end
      endcase
    end
  end

  // Reset itself never touches the array; only the sequence does.
  assign clear_write = (state == CLEAR) && !reset;

endmodule

// File: rtl/bram_dp.sv
// True dual-port block RAM with byte-lane writes, configurable same-port
// read-during-write, optional output register and post-reset clearing.
module bram_dp
  import bram_pkg::*;
#(
  parameter int RAM_WIDTH      = 32,
  parameter int RAM_ADDR_BITS  = 10,
  parameter int BYTE_WIDTH     = 8,
  parameter int RDW_MODE       = 0,
  parameter int OUTPUT_REG     = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                                     clock,
  input  logic                                     reset,
  output logic                                     init_busy,
  input  logic                                     a_enable,
  input  logic [calc_nbytes(RAM_WIDTH, BYTE_WIDTH)-1:0] a_write_enable,
  input  logic [RAM_ADDR_BITS-1:0]                 a_address,
  input  logic [RAM_WIDTH-1:0]                     a_input_data,
  output logic [RAM_WIDTH-1:0]                     a_output_data,
  output logic                                     a_valid,
  input  logic                                     b_enable,
  input  logic [calc_nbytes(RAM_WIDTH, BYTE_WIDTH)-1:0] b_write_enable,
  input  logic [RAM_ADDR_BITS-1:0]                 b_address,
  input  logic [RAM_WIDTH-1:0]                     b_input_data,
  output logic [RAM_WIDTH-1:0]                     b_output_data,
  output logic                                     b_valid
);

  localparam int NBYTES = calc_nbytes(RAM_WIDTH, BYTE_WIDTH);
  localparam int DEPTH  = 2 ** RAM_ADDR_BITS;

  if ((RAM_WIDTH % BYTE_WIDTH) != 0 || RDW_MODE < 0 || RDW_MODE > 2) begin : g_bad_params
    $error("bram_dp: RAM_WIDTH must be a multiple of BYTE_WIDTH and RDW_MODE must be 0..2");
  end

  function automatic logic [RAM_WIDTH-1:0] merge_lanes(
    input logic [RAM_WIDTH-1:0] old_word,
    input logic [RAM_WIDTH-1:0] new_word,
    input logic [NBYTES-1:0]    lanes
  );
    logic [RAM_WIDTH-1:0] word;
    word = old_word;
    for (int i = 0; i < NBYTES; i++) begin
      if (lanes[i]) begin
        word[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
    return word;
  endfunction

  logic                     clear_write;
  logic [RAM_ADDR_BITS-1:0] clear_addr;

  bram_clear_fsm #(
    .ADDR_BITS      (RAM_ADDR_BITS),
    .CLEAR_ON_RESET (CLEAR_ON_RESET != 0)
  ) u_clear (
    .clock       (clock),
    .reset       (reset),
    .init_busy   (init_busy),
    .clear_write (clear_write),
    .clear_addr  (clear_addr)
  );

  logic                     access_ok;
  logic                     a_access;
  logic                     b_access;
  logic [NBYTES-1:0]        a_lanes;
  logic [NBYTES-1:0]        b_lanes;
  logic [NBYTES-1:0]        wa_lanes;
  logic [RAM_ADDR_BITS-1:0] wa_addr;
  logic [RAM_WIDTH-1:0]     wa_data;

  assign access_ok = !reset && !init_busy;
  assign a_access  = a_enable && access_ok;
  assign b_access  = b_enable && access_ok;
  assign a_lanes   = a_access ? a_write_enable : '0;
  assign b_lanes   = b_access ? b_write_enable : '0;

  // The clear sequencer borrows port A's write path while it runs.
  assign wa_lanes = clear_write ? '1 : a_lanes;
  assign wa_addr  = clear_write ? clear_addr : a_address;
  assign wa_data  = clear_write ? '0 : a_input_data;

  logic [RAM_WIDTH-1:0] mem [DEPTH];

  // Port B lands first so port A wins any lane both ports strobe.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NBYTES; i++) begin
      if (b_lanes[i]) begin
        mem[b_address][i*BYTE_WIDTH +: BYTE_WIDTH] <= b_input_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
      if (wa_lanes[i]) begin
        mem[wa_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wa_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  logic [RAM_WIDTH-1:0] a_data_r;
  logic [RAM_WIDTH-1:0] b_data_r;
  logic                 a_valid_r;
  logic                 b_valid_r;

  // Port A read stage; mem reads here see the pre-write word.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_data_r  <= '0;
      a_valid_r <= 1'b0;
    end else if (a_access) begin
      if (a_write_enable == '0) begin
        a_data_r  <= mem[a_address];
        a_valid_r <= 1'b1;
      end else begin
        case (RDW_MODE)
          RDW_READ_FIRST: begin
            a_data_r  <= mem[a_address];
            a_valid_r <= 1'b1;
          end
          RDW_WRITE_FIRST: begin
            a_data_r  <= merge_lanes(mem[a_address], a_input_data, a_write_enable);
            a_valid_r <= 1'b1;
          end
          default: a_valid_r <= 1'b0;
        endcase
      end
    end else begin
      a_valid_r <= 1'b0;
    end
  end

  // Port B read stage, same rules as port A.
  always_ff @(posedge clock) begin
    if (reset) begin
      b_data_r  <= '0;
      b_valid_r <= 1'b0;
    end else if (b_access) begin
      if (b_write_enable == '0) begin
        b_data_r  <= mem[b_address];
        b_valid_r <= 1'b1;
      end else begin
        case (RDW_MODE)
          RDW_READ_FIRST: begin
            b_data_r  <= mem[b_address];
            b_valid_r <= 1'b1;
          end
          RDW_WRITE_FIRST: begin
            b_data_r  <= merge_lanes(mem[b_address], b_input_data, b_write_enable);
            b_valid_r <= 1'b1;
          end
          default: b_valid_r <= 1'b0;
        endcase
      end
    end else begin
      b_valid_r <= 1'b0;
    end
  end

  if (OUTPUT_REG != 0) begin : g_out_reg
    logic [RAM_WIDTH-1:0] a_out_r;
    logic [RAM_WIDTH-1:0] b_out_r;
    logic                 a_vout_r;
    logic                 b_vout_r;

    // Second pipeline stage; reset discards anything in flight.
    always_ff @(posedge clock) begin
      if (reset) begin
        a_out_r  <= '0;
        b_out_r  <= '0;
        a_vout_r <= 1'b0;
        b_vout_r <= 1'b0;
      end else begin
        a_out_r  <= a_data_r;
        b_out_r  <= b_data_r;
        a_vout_r <= a_valid_r;
        b_vout_r <= b_valid_r;
      end
    end

    assign a_output_data = a_out_r;
    assign b_output_data = b_out_r;
    assign a_valid       = a_vout_r;
    assign b_valid       = b_vout_r;
  end else begin : g_no_out_reg
    assign a_output_data = a_data_r;
    assign b_output_data = b_data_r;
    assign a_valid       = a_valid_r;
    assign b_valid       = b_valid_r;
  end

endmodule
